approx_mul8_seq: RTL and testbench

APPROX_MUL8_SEQ -- requirements
Module: approx_mul8_seq

---
 rtl/approx_mul8_seq.sv | 171 +++++++++++++++++
 tb/tb_approx_mul8_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/approx_mul8_seq.sv
// Sequential approximate 8x8 multiplier built around one time-shared approx_1 4x4 core.
// Optional APPROX_MUL8_SKIP_ZERO_EN skips nibble steps whose high operand nibble is zero.

// 4x4 approximate core: four 2x2 blocks, each exact except 3*3 -> 7.
module approx_1 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [7:0] p
);
   function automatic logic [3:0] mul2(input logic [1:0] u, input logic [1:0] v);
      return (u == 2'd3 && v == 2'd3) ? 4'd7 : ({2'b00, u} * {2'b00, v});
   endfunction

   assign p = 8'(mul2(x[1:0], y[1:0]))
            + (8'(mul2(x[3:2], y[1:0])) << 2)
            + (8'(mul2(x[1:0], y[3:2])) << 2)
            + (8'(mul2(x[3:2], y[3:2])) << 4);
endmodule

module approx_mul8_seq #(
   parameter int unsigned PIPE_CORE = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] product,
   output logic        busy
);
   localparam int unsigned OW = 8;
   localparam int unsigned NW = 4;
   localparam int unsigned PW = 16;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state, state_next;
   logic [1:0]      step, step_next, step_succ;
   logic            phase, phase_next;
   logic            load, core_en, acc_en, last;
   logic [OW-1:0]   a_q, b_q, core_q, core_res, acc_add;
   logic [NW-1:0]   core_x, core_y, shift;
   logic [PW-1:0]   acc;

   // Operand nibble selection for the current step: step[0] picks aH, step[1] picks bH.
   assign core_x = step[0] ? a_q[7:4] : a_q[3:0];
   assign core_y = step[1] ? b_q[7:4] : b_q[3:0];

   approx_1 u_core (
      .x (core_x),
      .y (core_y),
      .p (core_res)
   );

   assign acc_add = (PIPE_CORE != 0) ? core_q : core_res;
   assign product = acc;

   always_comb begin
      case (step)
         2'd0:    shift = 4'd0;
         2'd3:    shift = 4'd8;
         default: shift = 4'd4;
      endcase
   end

   // Next executed step after the current one; last is set when none remains.
`ifdef APPROX_MUL8_SKIP_ZERO_EN
   always_comb begin
      step_succ = step;
      last      = 1'b0;
      case (step)
         2'd0: begin
            if (a_q[7:4] != 4'd0)      step_succ = 2'd1;
            else if (b_q[7:4] != 4'd0) step_succ = 2'd2;
            else                       last      = 1'b1;
         end
         2'd1: begin
            if (b_q[7:4] != 4'd0) step_succ = 2'd2;
            else                  last      = 1'b1;
         end
         2'd2: begin
            if (a_q[7:4] != 4'd0) step_succ = 2'd3;
            else                  last      = 1'b1;
         end
         default: last = 1'b1;
      endcase
   end
`else
   always_comb begin
      step_succ = step + 2'd1;
      last      = (step == 2'd3);
   end
`endif

   always_comb begin
      state_next = state;
      step_next  = step;
      phase_next = phase;
      load       = 1'b0;
      core_en    = 1'b0;
      acc_en     = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               load       = 1'b1;
               step_next  = 2'd0;
               phase_next = 1'b0;
               state_next = CALC;
            end
         end
         CALC: begin
            if (PIPE_CORE != 0 && !phase) begin
               core_en    = 1'b1;
               phase_next = 1'b1;
            end else begin
               acc_en     = 1'b1;
               phase_next = 1'b0;
               if (last) begin
                  step_next  = 2'd0;
                  state_next = DONE;
               end else begin
                  step_next  = step_succ;
               end
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register with handshake/status outputs registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         step      <= 2'd0;
         phase     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         step      <= step_next;
         phase     <= phase_next;
         in_ready  <= (state_next == IDLE);
         out_valid <= (state_next == DONE);
         busy      <= (state_next != IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         core_q <= '0;
         acc    <= '0;
      end else begin
         if (load) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
         end
         if (core_en) core_q <= core_res;
         if (acc_en)  acc    <= acc + (PW'(acc_add) << shift);
      end
   end
endmodule

// File: tb/tb_approx_mul8_seq.sv
// Self-checking bench for approx_mul8_seq: one PIPE_CORE=0 and one PIPE_CORE=1 instance,
// directed vector table, reset abort sequence and randomized transactions against a digit-level model.
module tb_approx_mul8_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [7:0]  a = '0, b = '0;

   logic        iv0, iv1, or0, or1;
   logic        ir0, ir1, ov0, ov1, bs0, bs1;
   logic [15:0] pr0, pr1;
   logic        cur_ir, cur_ov, cur_bs;
   logic [15:0] cur_pr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign iv0 = in_valid & ~sel;
   assign iv1 = in_valid &  sel;
   assign or0 = out_ready & ~sel;
   assign or1 = out_ready &  sel;
   assign cur_ir = sel ? ir1 : ir0;
   assign cur_ov = sel ? ov1 : ov0;
   assign cur_bs = sel ? bs1 : bs0;
   assign cur_pr = sel ? pr1 : pr0;

   approx_mul8_seq #(.PIPE_CORE(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
      .out_valid(ov0), .out_ready(or0), .product(pr0), .busy(bs0));

   approx_mul8_seq #(.PIPE_CORE(1)) dut_p (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
      .out_valid(ov1), .out_ready(or1), .product(pr1), .busy(bs1));

   // Reference: sum of all 2-bit digit products, 3*3 approximated as 7.
   function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
      int sum = 0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            int dx = (x >> (2*i)) & 3;
            int dy = (y >> (2*j)) & 3;
            int p  = (dx == 3 && dy == 3) ? 7 : dx * dy;
            sum += p << (2*(i+j));
         end
      end
      return 16'(sum);
   endfunction

   function automatic int ref_lat(input logic [7:0] x, input logic [7:0] y, input int pipe);
      int steps;
`ifdef APPROX_MUL8_SKIP_ZERO_EN
      steps = 1;
      if (x[7:4] != 0) steps++;
      if (y[7:4] != 0) steps++;
      if (x[7:4] != 0 && y[7:4] != 0) steps++;
`else
      steps = 4;
`endif
      return steps * (1 + pipe);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One full transaction on the selected instance; garbage operands with in_valid high during CALC.
   task automatic do_txn(input logic [7:0] ta, input logic [7:0] tb_, input int hold,
                         input logic [15:0] exp_p, input string nm);
      int lat;
      int exp_lat;
      exp_lat = ref_lat(ta, tb_, sel ? 1 : 0);
      a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b0;
      chk({nm, "_ready_pre"}, 32'(cur_ir), 32'd1);
      @(posedge clk); #1;
      a = 8'($urandom); b = 8'($urandom);
      lat = 0;
      while (lat < 40) begin
         chk({nm, "_busy_rdy"}, {30'd0, cur_bs, cur_ir}, 32'b10);
         @(posedge clk); #1;
         lat++;
         a = 8'($urandom); b = 8'($urandom);
         if (cur_ov) break;
      end
      in_valid = 1'b0;
      chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, "_product"}, 32'(cur_pr), 32'(exp_p));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk({nm, "_hold"}, {14'd0, cur_ov, cur_ir, cur_pr}, {14'd0, 1'b1, 1'b0, exp_p});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, "_release"}, {29'd0, cur_ov, cur_ir, cur_bs}, {29'd0, 3'b010});
   endtask

   typedef struct {
      logic [7:0]  ta;
      logic [7:0]  tb;
      int          hold;
      logic        pipe;
      logic [15:0] exp_p;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{8'hFF, 8'hFF, 0, 1'b0, 16'hC58F};
      vecs[1] = '{8'h12, 8'h03, 0, 1'b0, 16'h0036};
      vecs[2] = '{8'h00, 8'h55, 2, 1'b0, 16'h0000};
      vecs[3] = '{8'hFF, 8'hFF, 3, 1'b0, 16'hC58F};
      vecs[4] = '{8'hFF, 8'hFF, 1, 1'b1, 16'hC58F};
      vecs[5] = '{8'h12, 8'h03, 0, 1'b1, 16'h0036};

      #12;
      chk("reset_p0", {13'd0, ir0, ov0, bs0, pr0}, {13'd0, 3'b100, 16'h0000});
      chk("reset_p1", {13'd0, ir1, ov1, bs1, pr1}, {13'd0, 3'b100, 16'h0000});
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         sel = vecs[i].pipe;
         do_txn(vecs[i].ta, vecs[i].tb, vecs[i].hold, vecs[i].exp_p, $sformatf("vec%0d", i));
      end

      // Reset abort while step2 of 0xFF*0xFF is pending.
      sel = 1'b0;
      a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_reset", {13'd0, ir0, ov0, bs0, pr0}, {13'd0, 3'b100, 16'h0000});
      #2;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("abort_idle", {13'd0, ir0, ov0, bs0, pr0}, {13'd0, 3'b100, 16'h0000});
      end
      do_txn(8'h12, 8'h03, 0, 16'h0036, "after_abort");

      // Randomized transactions on both instances, with biased zero high nibbles.
      for (int r = 0; r < 24; r++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(0, 3) == 0) ra[7:4] = 4'd0;
         if ($urandom_range(0, 3) == 0) rb[7:4] = 4'd0;
         sel = r[0];
         do_txn(ra, rb, $urandom_range(0, 2), ref_mul(ra, rb), $sformatf("rnd%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
